// File: rtl/pll_reconfig_seq.sv
// Avalon-MM sequencer that retunes the system PLL between PAL (0) and NTSC (1) fractional M/K profiles.
// Latency: 9 writes at >=2 cycles each, then waits up to LOCK_TIMEOUT cycles for relock; done/busy-fall on the same edge.
// Backpressure: address/data/strobe held while avm_waitrequest=1; optional readback via `define PLL_RECFG_READBACK_EN.
module pll_reconfig_seq #(
    parameter logic [31:0] N_CNT        = 32'h0001_0000,
    parameter logic [31:0] M_PAL        = 32'h0000_0504,
    parameter logic [31:0] K_PAL        = 32'd858993373,
    parameter logic [31:0] M_NTSC       = 32'h0000_0504,
    parameter logic [31:0] K_NTSC       = 32'd1288490189,
    parameter logic [17:0] C_CNT0       = 18'h00202,
    parameter logic [17:0] C_CNT1       = 18'h00202,
    parameter logic [17:0] C_CNT2       = 18'h00404,
    parameter logic [17:0] C_CNT3       = 18'h00808,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned LOCK_TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        mode_sel,
    input  logic        pll_locked,
    output logic [5:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cur_mode
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WR        = 2'd1,
        S_RD        = 2'd2,
        S_WAIT_LOCK = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SETTLE_V  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       IDX_LAST  = 4'd8;

    state_t           state_q, state_d;
    logic [3:0]       idx_q;
    logic             strb_q;
    logic             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             error_q;
    logic             cur_mode_q;
    logic             lock_meta, lock_s;

    logic [5:0]       tbl_addr;
    logic [31:0]      tbl_data;
    logic             xfer;
    logic             last_wr;
    logic             wr_to_rd;
    logic             rd_bad;
    logic             lock_ok;
    logic             lock_to;

    // pll_locked is asynchronous to clk; only the synchronised copy is used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Write table; the start command (index 8) is always last.
    always_comb begin
        tbl_addr = 6'd0;
        tbl_data = 32'd0;
        case (idx_q)
            4'd0: begin tbl_addr = 6'd0; tbl_data = 32'd0;                          end
            4'd1: begin tbl_addr = 6'd3; tbl_data = N_CNT;                          end
            4'd2: begin tbl_addr = 6'd4; tbl_data = sel_q ? M_NTSC : M_PAL;         end
            4'd3: begin tbl_addr = 6'd7; tbl_data = sel_q ? K_NTSC : K_PAL;         end
            4'd4: begin tbl_addr = 6'd5; tbl_data = {9'd0, 5'd0, C_CNT0};           end
            4'd5: begin tbl_addr = 6'd5; tbl_data = {9'd0, 5'd1, C_CNT1};           end
            4'd6: begin tbl_addr = 6'd5; tbl_data = {9'd0, 5'd2, C_CNT2};           end
            4'd7: begin tbl_addr = 6'd5; tbl_data = {9'd0, 5'd3, C_CNT3};           end
            default: begin tbl_addr = 6'd2; tbl_data = 32'd0;                       end
        endcase
    end

    assign xfer    = strb_q && !avm_waitrequest;
    assign last_wr = (idx_q == IDX_LAST);
    assign lock_ok = (cnt_q >= SETTLE_V) && lock_s;
    assign lock_to = (cnt_q == TIMEOUT_V);

`ifdef PLL_RECFG_READBACK_EN
    logic [31:0] rd_mask;
    // C counter words carry the counter select above bit 17; only the value is read back.
    assign rd_mask  = (idx_q >= 4'd4) ? 32'h0003_FFFF : 32'hFFFF_FFFF;
    assign wr_to_rd = (idx_q >= 4'd1) && (idx_q <= 4'd7);
    assign rd_bad   = |((avm_readdata ^ tbl_data) & rd_mask);
`else
    logic unused_rdata;
    assign unused_rdata = ^avm_readdata;
    assign wr_to_rd     = 1'b0;
    assign rd_bad       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_WR;
            end
            S_WR: begin
                if (xfer) begin
                    if (last_wr)       state_d = S_WAIT_LOCK;
                    else if (wr_to_rd) state_d = S_RD;
                end
            end
            S_RD: begin
                if (xfer) state_d = rd_bad ? S_IDLE : S_WR;
            end
            S_WAIT_LOCK: begin
                if (lock_ok || lock_to) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= 4'd0;
            strb_q     <= 1'b0;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cur_mode_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_WAIT_LOCK) cnt_q <= '0;
            case (state_q)
                S_IDLE: begin
                    strb_q <= 1'b0;
                    if (req) begin
                        sel_q   <= mode_sel;
                        error_q <= 1'b0;
                        idx_q   <= 4'd0;
                    end
                end
                S_WR: begin
                    // Strobe alternates with one idle cycle between transfers.
                    if (!strb_q) begin
                        strb_q <= 1'b1;
                    end else if (xfer) begin
                        strb_q <= 1'b0;
                        if (!last_wr && !wr_to_rd) idx_q <= idx_q + 4'd1;
                    end
                end
                S_RD: begin
                    if (!strb_q) begin
                        strb_q <= 1'b1;
                    end else if (xfer) begin
                        strb_q <= 1'b0;
                        if (rd_bad) error_q <= 1'b1;
                        else        idx_q   <= idx_q + 4'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                    if (lock_ok) begin
                        done_q     <= 1'b1;
                        cur_mode_q <= sel_q;
                    end else if (lock_to) begin
                        error_q <= 1'b1;
                    end
                end
                default: strb_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        avm_address   = tbl_addr;
        avm_writedata = tbl_data;
        avm_write     = (state_q == S_WR) && strb_q;
`ifdef PLL_RECFG_READBACK_EN
        avm_read      = (state_q == S_RD) && strb_q;
`else
        avm_read      = 1'b0;
`endif
        busy          = (state_q != S_IDLE);
        done          = done_q;
        error         = error_q;
        cur_mode      = cur_mode_q;
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: reset, NTSC retune, stalled bus, lock timeout, mid-sequence reset, readback error.
module tb_pll_reconfig_seq;

    localparam int unsigned LT = 1000;
`ifdef PLL_RECFG_READBACK_EN
    localparam int RB_EXTRA = 14;
`else
    localparam int RB_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        mode_sel;
    logic        pll_locked;
    logic [5:0]  avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        error;
    logic        cur_mode;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0]  wa_q [$];
    logic [31:0] wd_q [$];
    logic [31:0] mem [0:63];
    int          done_total = 0;
    int          rd_total   = 0;
    int          stab_err   = 0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_a     = 6'd0;
    logic [31:0] prev_d     = 32'd0;

    logic [5:0]  stall_addr = 6'd4;
    int          stall_len  = 0;
    int          scnt       = 0;
    logic        corrupt_k  = 1'b0;

    always #5 clk = ~clk;

    pll_reconfig_seq #(.LOCK_TIMEOUT(LT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .mode_sel       (mode_sel),
        .pll_locked     (pll_locked),
        .avm_address    (avm_address),
        .avm_writedata  (avm_writedata),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .cur_mode       (cur_mode)
    );

    // Bus monitor: logs completed writes, checks stability under stall.
    always @(negedge clk) begin
        if (prev_stall && reset_n &&
            (!avm_write || avm_address != prev_a || avm_writedata != prev_d))
            stab_err <= stab_err + 1;
        prev_stall <= avm_write && avm_waitrequest;
        prev_a     <= avm_address;
        prev_d     <= avm_writedata;
        if (avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
            mem[avm_address] <= avm_writedata;
        end
        if (avm_read) rd_total <= rd_total + 1;
        if (done) done_total <= done_total + 1;
    end

    // Slave model: programmable stall on one address, read returns last write.
    initial begin
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (avm_write && avm_address == stall_addr) begin
                avm_waitrequest = (scnt < stall_len);
                scnt = scnt + 1;
            end else begin
                avm_waitrequest = 1'b0;
                scnt = 0;
            end
            avm_readdata = mem[avm_address] ^ ((corrupt_k && avm_address == 6'd7) ? 32'h1 : 32'h0);
        end
    end

    task automatic pulse_req(input logic m);
        @(posedge clk); #1;
        req = 1'b1; mode_sel = m;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_wr_end(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            if (avm_write && !avm_waitrequest && avm_address == 6'd2) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(input int budget, output int n, output bit saw_done,
                            output bit busy_at_done, output bit hit);
        n = 0; saw_done = 1'b0; busy_at_done = 1'b1; hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                saw_done = 1'b1; busy_at_done = busy; hit = 1'b1;
                break;
            end
            if (error) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int viol;
        reset_n = 1'b0; req = 1'b0; mode_sel = 1'b0; pll_locked = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_chk++; if ({busy, done, error, cur_mode} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_status: got %b want 0000", {busy, done, error, cur_mode}); end
        n_chk++; if ({avm_write, avm_read} !== 2'b00) begin n_fail++;
            $display("FAIL reset_strobes: got %b want 00", {avm_write, avm_read}); end
        n_chk++; if (avm_address !== 6'd0 || avm_writedata !== 32'd0) begin n_fail++;
            $display("FAIL reset_bus: addr %0d data %h want 0/0", avm_address, avm_writedata); end
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (avm_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        n_chk++; if (viol != 0) begin n_fail++;
            $display("FAIL idle_quiet: %0d active cycles, want 0", viol); end
    endtask

    task automatic test_ntsc;
        logic [5:0] exp_a [9];
        int base, dbase, cyc, n, bad;
        bit ok, sd, bd, hit;
        exp_a = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd5, 6'd2};
        base = wa_q.size(); dbase = done_total;
        pll_locked = 1'b0;
        pulse_req(1'b1);
        wait_wr_end(cyc, ok);
        n_chk++; if (!ok || cyc != 18 + RB_EXTRA) begin n_fail++;
            $display("FAIL ntsc_wr_cycles: got %0d (ok=%0d) want %0d", cyc, ok, 18 + RB_EXTRA); end
        repeat (480) @(posedge clk);
        n_chk++; if (done_total != dbase || busy !== 1'b1) begin n_fail++;
            $display("FAIL ntsc_no_early_done: done %0d busy %b want 0/1", done_total - dbase, busy); end
        #1 pll_locked = 1'b1;
        wait_end(100, n, sd, bd, hit);
        n_chk++; if (!sd) begin n_fail++;
            $display("FAIL ntsc_done: got saw_done=%0d error=%b want done", sd, error); end
        n_chk++; if (bd !== 1'b0) begin n_fail++;
            $display("FAIL ntsc_busy_on_done: busy %b want 0", bd); end
        repeat (3) @(negedge clk);
        n_chk++; if (done_total - dbase != 1) begin n_fail++;
            $display("FAIL ntsc_done_once: got %0d pulses want 1", done_total - dbase); end
        n_chk++; if (cur_mode !== 1'b1 || error !== 1'b0) begin n_fail++;
            $display("FAIL ntsc_mode: cur_mode %b error %b want 1/0", cur_mode, error); end
        n_chk++; if (wa_q.size() - base != 9) begin n_fail++;
            $display("FAIL ntsc_wr_count: got %0d want 9", wa_q.size() - base); end
        if (wa_q.size() - base >= 9) begin
            bad = 0;
            for (int i = 0; i < 9; i++) if (wa_q[base+i] !== exp_a[i]) bad++;
            n_chk++; if (bad != 0) begin n_fail++;
                $display("FAIL ntsc_addr_order: %0d wrong addresses want 0", bad); end
            n_chk++; if (wd_q[base+3] !== 32'd1288490189) begin n_fail++;
                $display("FAIL ntsc_k_data: got %0d want 1288490189", wd_q[base+3]); end
            n_chk++; if (wd_q[base+6] !== 32'h0008_0404) begin n_fail++;
                $display("FAIL ntsc_c2_data: got %h want 00080404", wd_q[base+6]); end
            n_chk++; if (wd_q[base+1] !== 32'h0001_0000 || wd_q[base+2] !== 32'h0000_0504) begin n_fail++;
                $display("FAIL ntsc_nm_data: got %h/%h want 00010000/00000504", wd_q[base+1], wd_q[base+2]); end
        end
    endtask

    task automatic test_stall;
        int base, sbase, cyc, n;
        bit ok, sd, bd, hit;
        base = wa_q.size(); sbase = stab_err;
        stall_addr = 6'd4; stall_len = 7;
        pulse_req(1'b0);
        wait_wr_end(cyc, ok);
        n_chk++; if (!ok || cyc != 25 + RB_EXTRA) begin n_fail++;
            $display("FAIL stall_wr_cycles: got %0d (ok=%0d) want %0d", cyc, ok, 25 + RB_EXTRA); end
        wait_end(200, n, sd, bd, hit);
        stall_len = 0;
        repeat (2) @(negedge clk);
        n_chk++; if (stab_err != sbase) begin n_fail++;
            $display("FAIL stall_stable: %0d unstable cycles want 0", stab_err - sbase); end
        n_chk++; if (!sd || cur_mode !== 1'b0) begin n_fail++;
            $display("FAIL stall_done: done %0d cur_mode %b want 1/0", sd, cur_mode); end
        if (wa_q.size() - base >= 9) begin
            n_chk++; if (wa_q[base+2] !== 6'd4 || wd_q[base+2] !== 32'h0000_0504 ||
                         wa_q[base+3] !== 6'd7 || wd_q[base+3] !== 32'd858993373) begin n_fail++;
                $display("FAIL stall_mk: got %0d:%h %0d:%h want 4:00000504 7:%h",
                         wa_q[base+2], wd_q[base+2], wa_q[base+3], wd_q[base+3], 32'd858993373); end
            n_chk++; if (wa_q[base+8] !== 6'd2) begin n_fail++;
                $display("FAIL stall_last: got addr %0d want 2", wa_q[base+8]); end
        end else begin
            n_chk++; n_fail++;
            $display("FAIL stall_wr_count: got %0d want 9", wa_q.size() - base);
        end
    endtask

    task automatic test_timeout;
        int dbase, cyc, n;
        bit ok, sd, bd, hit;
        dbase = done_total;
        pll_locked = 1'b0;
        pulse_req(1'b1);
        wait_wr_end(cyc, ok);
        wait_end(LT + 50, n, sd, bd, hit);
        n_chk++; if (!hit || sd || error !== 1'b1 || n != LT + 1) begin n_fail++;
            $display("FAIL timeout_error: hit %0d done %0d error %b at %0d want error at %0d",
                     hit, sd, error, n, LT + 1); end
        @(negedge clk);
        n_chk++; if (cur_mode !== 1'b0 || busy !== 1'b0 || done_total != dbase) begin n_fail++;
            $display("FAIL timeout_state: cur_mode %b busy %b dones %0d want 0/0/0",
                     cur_mode, busy, done_total - dbase); end
        pll_locked = 1'b1;
        pulse_req(1'b1);
        @(negedge clk);
        n_chk++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL timeout_clear: error %b busy %b want 0/1", error, busy); end
        wait_wr_end(cyc, ok);
        wait_end(200, n, sd, bd, hit);
        n_chk++; if (!sd || cur_mode !== 1'b1) begin n_fail++;
            $display("FAIL timeout_recover: done %0d cur_mode %b want 1/1", sd, cur_mode); end
    endtask

    task automatic test_reset_mid;
        int base, cyc, n;
        bit ok, sd, bd, hit, found;
        found = 1'b0;
        pulse_req(1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (avm_write && avm_address == 6'd7) begin found = 1'b1; break; end
        end
        reset_n = 1'b0;
        #1;
        n_chk++; if (!found || avm_write !== 1'b0 || busy !== 1'b0 || avm_address !== 6'd0) begin n_fail++;
            $display("FAIL midreset_drop: found %0d write %b busy %b addr %0d want 1/0/0/0",
                     found, avm_write, busy, avm_address); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_chk++; if (cur_mode !== 1'b0 || error !== 1'b0) begin n_fail++;
            $display("FAIL midreset_state: cur_mode %b error %b want 0/0", cur_mode, error); end
        base = wa_q.size();
        pulse_req(1'b1);
        wait_wr_end(cyc, ok);
        wait_end(200, n, sd, bd, hit);
        n_chk++; if (wa_q.size() - base != 9 || wa_q[base] !== 6'd0 || wd_q[base] !== 32'd0) begin n_fail++;
            $display("FAIL midreset_restart: %0d writes first addr %0d want 9 writes from 0",
                     wa_q.size() - base, (wa_q.size() > base) ? wa_q[base] : 6'h3f); end
        n_chk++; if (!sd || cur_mode !== 1'b1) begin n_fail++;
            $display("FAIL midreset_done: done %0d cur_mode %b want 1/1", sd, cur_mode); end
    endtask

`ifdef PLL_RECFG_READBACK_EN
    task automatic test_readback;
        int base, dbase, rbase, cyc, n, starts;
        bit sd, bd, hit;
        base = wa_q.size(); dbase = done_total; rbase = rd_total;
        corrupt_k = 1'b1;
        pulse_req(1'b0);
        wait_end(300, n, sd, bd, hit);
        repeat (3) @(negedge clk);
        corrupt_k = 1'b0;
        starts = 0;
        for (int i = base; i < wa_q.size(); i++) if (wa_q[i] == 6'd2) starts++;
        cyc = wa_q.size() - base;
        n_chk++; if (!hit || error !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL readback_error: hit %0d error %b busy %b want 1/1/0", hit, error, busy); end
        n_chk++; if (starts != 0 || done_total != dbase || cyc != 4) begin n_fail++;
            $display("FAIL readback_abort: starts %0d dones %0d writes %0d want 0/0/4",
                     starts, done_total - dbase, cyc); end
        n_chk++; if (rd_total - rbase != 3 || cur_mode !== 1'b1) begin n_fail++;
            $display("FAIL readback_reads: reads %0d cur_mode %b want 3/1", rd_total - rbase, cur_mode); end
    endtask
`endif

    initial begin
        test_reset();
        test_ntsc();
        test_stall();
        test_timeout();
        test_reset_mid();
`ifdef PLL_RECFG_READBACK_EN
        test_readback();
`else
        n_chk++; if (rd_total != 0) begin n_fail++;
            $display("FAIL no_reads: got %0d read cycles want 0", rd_total); end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
